// File: rtl/gf2m_digit_serial_multiplier.sv
// Digit-serial GF(2^W) multiplier, polynomial basis, programmable reduction
// polynomial. Consumes D bits of B per cycle, MSB first (Horner scheme),
// with valid/ready handshakes on operand and product sides.
module gf2m_digit_serial_multiplier #(
    parameter int unsigned    W    = 8,
    parameter logic [W-1:0]   POLY = 8'h1B,
    parameter int unsigned    D    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] O,
    output logic         busy
);

    localparam int unsigned STEPS = W / D;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    if ((W < 2) || (W > 32) || (D < 1) || (D > W) || ((W % D) != 0)) begin : g_illegal_params
        $error("gf2m_digit_serial_multiplier: W must be 2..32 and D must divide W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    o_q, o_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [W-1:0]    acc_shift;
    logic [W-1:0]    partial;
    logic [W-1:0]    a_pow;
    logic [D-1:0]    digit;
    logic [W-1:0]    step;

    // Multiply by x and reduce modulo the field polynomial.
    function automatic logic [W-1:0] mulx(input logic [W-1:0] v);
        return {v[W-2:0], 1'b0} ^ (v[W-1] ? POLY : '0);
    endfunction

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign O         = o_q;

    // One Horner step: acc*x^D plus the digit-weighted multiples a*x^j.
    always_comb begin
        acc_shift = acc_q;
        for (int unsigned i = 0; i < D; i++) begin
            acc_shift = mulx(acc_shift);
        end
        digit   = b_q[W-1 -: D];
        partial = '0;
        a_pow   = a_q;
        for (int unsigned j = 0; j < D; j++) begin
            if (digit[j]) begin
                partial = partial ^ a_pow;
            end
            a_pow = mulx(a_pow);
        end
        step = acc_shift ^ partial;
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = A;
                    b_d     = B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = step;
                b_d   = b_q << D;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    o_d     = step;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
        end
    end

endmodule

// File: tb/tb_gf2m_digit_serial_multiplier.sv
// Scoreboard bench: four configurations (W=8 D=1/2/8, W=4 D=1) driven with
// directed and random operands, checked against a carry-less multiply
// followed by polynomial long-division reduction.
module tb_gf2m_digit_serial_multiplier;

    localparam int N = 4;

    int          wid  [N] = '{8, 8, 8, 4};
    int          lat  [N] = '{8, 4, 1, 4};
    logic [7:0]  poly [N] = '{8'h1B, 8'h1B, 8'h1B, 8'h03};

    logic        clk = 1'b0;
    logic        rst;
    logic [N-1:0] in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  a_s [N];
    logic [7:0]  b_s [N];
    logic [7:0]  o0, o1, o2;
    logic [3:0]  o3;

    typedef struct {
        int         k;
        logic [7:0] exp;
        int         acc_cyc;
    } ent_t;
    ent_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rnd_bp = 0;

    logic [N-1:0] prev_v, prev_r;
    logic [7:0]   prev_o [N];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    gf2m_digit_serial_multiplier #(.W(8), .POLY(8'h1B), .D(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .A(a_s[0]), .B(b_s[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .O(o0), .busy(busy[0]));

    gf2m_digit_serial_multiplier #(.W(8), .POLY(8'h1B), .D(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .A(a_s[1]), .B(b_s[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .O(o1), .busy(busy[1]));

    gf2m_digit_serial_multiplier #(.W(8), .POLY(8'h1B), .D(8)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .A(a_s[2]), .B(b_s[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .O(o2), .busy(busy[2]));

    gf2m_digit_serial_multiplier #(.W(4), .POLY(4'h3), .D(1)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .A(a_s[3][3:0]), .B(b_s[3][3:0]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .O(o3), .busy(busy[3]));

    function automatic logic [7:0] get_o(input int k);
        case (k)
            0:       return o0;
            1:       return o1;
            2:       return o2;
            default: return {4'h0, o3};
        endcase
    endfunction

    // Schoolbook carry-less product, then long division by the full modulus.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                           input int w, input logic [7:0] p);
        logic [15:0] prod;
        logic [15:0] modulus;
        prod    = '0;
        modulus = (16'd1 << w) | {8'h00, p};
        for (int i = 0; i < w; i++) begin
            if (b[i]) prod = prod ^ ({8'h00, a} << i);
        end
        for (int i = 2 * w - 2; i >= w; i--) begin
            if (prod[i]) prod = prod ^ (modulus << (i - w));
        end
        return prod[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency on rising out_valid, stability under backpressure,
    // product comparison on each output handshake.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!rst) begin
                if (out_valid[k] && !prev_v[k]) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("spurious_valid_%0d", k), 32'd1, 32'd0);
                    end else begin
                        chk($sformatf("inst_%0d", k), sb[0].k, k);
                        chk($sformatf("latency_%0d", k), cyc - sb[0].acc_cyc, lat[k]);
                    end
                end
                if (prev_v[k] && !prev_r[k]) begin
                    chk($sformatf("hold_valid_%0d", k), out_valid[k], 1'b1);
                    chk($sformatf("hold_O_%0d", k), get_o(k), prev_o[k]);
                end
                if (out_valid[k] && out_ready[k]) begin
                    if (sb.size() == 0) begin
                        chk($sformatf("unexpected_output_%0d", k), 32'd1, 32'd0);
                    end else begin
                        chk($sformatf("product_%0d", k), get_o(k), sb[0].exp);
                        void'(sb.pop_front());
                    end
                end
            end
            prev_v[k] <= out_valid[k];
            prev_r[k] <= out_ready[k];
            prev_o[k] <= get_o(k);
        end
    end

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = N'($urandom);
        end
    end

    task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b,
                         input bit hold, input bit has_exp, input logic [7:0] exp_in);
        logic [7:0] m;
        logic [7:0] e;
        bit got;
        m = (wid[k] == 4) ? 8'h0F : 8'hFF;
        e = has_exp ? exp_in : ref_mul(a & m, b & m, wid[k], poly[k]);
        @(posedge clk);
        #1;
        a_s[k] = a;
        b_s[k] = b;
        in_valid[k] = 1'b1;
        got = 0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            if (in_ready[k]) begin
                sb.push_back('{k: k, exp: e, acc_cyc: cyc + 1});
                got = 1;
            end
        end
        if (!got) chk($sformatf("accept_timeout_%0d", k), 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) begin
            in_valid[k] = 1'b0;
            a_s[k] = 8'($urandom);
            b_s[k] = 8'($urandom);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        logic [7:0] held;
        bit seen;
        rst = 1'b1;
        in_valid = '0;
        out_ready = '1;
        for (int k = 0; k < N; k++) begin
            a_s[k] = '0;
            b_s[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_out_valid_%0d", k), out_valid[k], 1'b0);
            chk($sformatf("rst_busy_%0d", k), busy[k], 1'b0);
            chk($sformatf("rst_in_ready_%0d", k), in_ready[k], 1'b0);
            chk($sformatf("rst_O_%0d", k), get_o(k), 8'h00);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) chk($sformatf("post_rst_in_ready_%0d", k), in_ready[k], 1'b1);

        // Directed products with known answers.
        issue(0, 8'h57, 8'h83, 0, 1, 8'hC1); drain();
        issue(0, 8'h57, 8'h13, 0, 1, 8'hFE); drain();
        issue(0, 8'hA5, 8'h00, 0, 1, 8'h00); drain();
        issue(0, 8'h00, 8'h6C, 0, 1, 8'h00); drain();
        issue(0, 8'hA5, 8'h01, 0, 1, 8'hA5); drain();
        issue(1, 8'h57, 8'h83, 0, 1, 8'hC1); drain();
        issue(2, 8'h57, 8'h83, 0, 1, 8'hC1); drain();
        issue(2, 8'h57, 8'h13, 0, 1, 8'hFE); drain();
        issue(3, 8'h09, 8'h06, 0, 1, 8'h03); drain();
        issue(3, 8'h0F, 8'h01, 0, 1, 8'h0F); drain();
        issue(3, 8'h00, 8'h0A, 0, 1, 8'h00); drain();

        // Backpressure: hold out_ready low for 5 cycles in DONE.
        out_ready[0] = 1'b0;
        issue(0, 8'h3C, 8'hD7, 0, 0, 8'h00);
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid[0];
        end
        chk("bp_reach_done", seen, 1'b1);
        held = ref_mul(8'h3C, 8'hD7, 8, 8'h1B);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid[0], 1'b1);
            chk("bp_in_ready", in_ready[0], 1'b0);
            chk("bp_O", o0, held);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", in_ready[0], 1'b1);
        chk("bp_release_out_valid", out_valid[0], 1'b0);
        drain();

        // Reset in the middle of a computation.
        issue(0, 8'hC3, 8'h5A, 0, 0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        chk("midrst_out_valid", out_valid[0], 1'b0);
        chk("midrst_O", o0, 8'h00);
        chk("midrst_busy", busy[0], 1'b0);
        chk("midrst_in_ready", in_ready[0], 1'b0);
        rst = 1'b0;
        issue(0, 8'h57, 8'h83, 0, 1, 8'hC1); drain();

        // Back-to-back with in_valid held high.
        issue(0, 8'h12, 8'h34, 1, 0, 8'h00);
        issue(0, 8'hFF, 8'hFF, 1, 0, 8'h00);
        issue(0, 8'h80, 8'h02, 0, 0, 8'h00);
        drain();

        // Random sweep with random backpressure.
        rnd_bp = 1;
        for (int i = 0; i < 1000; i++) begin
            issue(i % N, 8'($urandom), 8'($urandom), 0, 0, 8'h00);
            drain();
        end
        rnd_bp = 0;
        @(posedge clk);
        #1;
        out_ready = '1;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
